aes_iter_core: RTL and testbench
================================

# aes_iter_core

Parametrised iterative AES block cipher core, the successor to the fixed AES-128 round FSM. It supports 128-, 192- and 256-bit keys, with key expansion done once per key into an internal round-key store. Each cipher round executes in one clock. It sits between the key-management logic and the data path, with valid/ready handshakes on key input, block input and block output.

## Interface
Parameters:
- KEY_BITS, 128, key length; legal values 128/192/256, any other value is an elaboration error
- Derived: NK = KEY_BITS/32, NR = NK+6, NW = 4*(NR+1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- key_valid  in  1  key_in valid
- key_ready  out  1  core accepts a new key this cycle
- key_in  in  KEY_BITS  cipher key, FIPS-197 byte order, MSB = byte 0
- in_valid  in  1  data_in valid
- in_ready  out  1  core accepts a block this cycle
- data_in  in  128  input block, MSB = byte 0
- decrypt  in  1  sampled with data_in; 1 = inverse cipher (present only with AES_DECRYPT_EN)
- out_valid  out  1  data_out holds a finished block
- out_ready  in  1  downstream accepts data_out
- data_out  out  128  result block
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- Key handshake:
  - key_ready = (state==IDLE). A handshake fires when key_valid && key_ready.
  - On that edge, write w[0..NK-1] from key_in, clear key_loaded, set word index i=NK, and go to KEYEXP.
- KEYEXP generates one word per cycle:
  - Base rule: w[i] = w[i-NK] ^ t, where t = w[i-1] by default.
  - If i%NK==0: t = SubWord(RotWord(w[i-1])) ^ {rcon[i/NK],24'h0}.
  - Else if NK==8 && i%NK==4: t = SubWord(w[i-1]).
  - After writing w[NW-1], set key_loaded=1 and return to IDLE.
- Block handshake:
  - in_ready = (state==IDLE) && key_loaded && !key_valid. A key request in the same cycle wins; the block is not taken.
  - On handshake: st <= data_in ^ rk[0] (encrypt), round counter r=1, go to ROUND.
- ROUND (encrypt):
  - r<NR: st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk[r].
  - r==NR: MixColumns is omitted. Load the result into data_out, set out_valid=1, go to DONE.
- DONE:
  - data_out and out_valid are held stable until out_ready.
  - On out_ready, clear out_valid and go to IDLE.
  - in_ready and key_ready are 0 in DONE.
- rk[r] = {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
- The round-key store is retained across blocks. A new key overwrites it and blocks data until expansion completes.

## Timing
- Reset values: state=IDLE, key_loaded=0, out_valid=0, data_out=0, busy=0, in_ready=0, key_ready=1.
- Key expansion latency: NW-NK cycles after the key handshake edge (40/46/52 for 128/192/256). key_ready returns high the cycle after the last word is written.
- Block latency: out_valid rises NR edges after the accepting edge (10/12/14). Throughput is one block per NR+2 cycles with out_ready held high.
- Reset mid-operation: abort immediately. Key store contents are don't-care; key_loaded=0, so a new key is required.
- in_valid while key_loaded==0: ignored, in_ready stays 0.

## Configuration
- AES_DECRYPT_EN defined:
  - Adds the decrypt port, inverse S-box instances and InvMixColumns.
  - A decrypt block uses st <= data_in ^ rk[NR], r=NR-1 counting down.
  - For r>0: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[r]).
  - At r==0: InvSubBytes(InvShiftRows(st)) ^ rk[0], with no InvMixColumns. Latency is identical to encrypt.
- Undefined: encrypt only. The decrypt port is absent and no inverse logic is built.

## Structure
- Package aes_pkg:
  - state enum.
  - nk_of/nr_of functions.
  - rcon table (10 entries).
  - xtime, gmul, mix_column and inv_mix_column functions.
  - shift_rows and inv_shift_rows functions.
- Sub-module aes_sbox:
  - Combinational 8-bit lookup, with parameter INV selecting the inverse table.
  - Instanced 16× for the round and 4× for SubWord.
  - A further 16× with INV=1 under AES_DECRYPT_EN.
- Core holds the FSM, round-key word array, counters and handshakes.

## Test plan
- KEY_BITS=128, key 000102…0f, block 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after accept, key_ready low 40 cycles.
- KEY_BITS=192, key 000102…17, same block -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 12, expansion 46 cycles.
- KEY_BITS=256, key 000102…1f, same block -> 8ea2b7ca516745bfeafc49904b496089, latency 14, expansion 52 cycles.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> data_out stable, in_ready=key_ready=0. Drop to IDLE the cycle after out_ready=1. Two back-to-back blocks with the same key give correct results without re-expansion.
- in_valid asserted before any key, then key_valid and in_valid together -> no block accepted until key_loaded. Assert rst_n=0 mid-ROUND -> out_valid=0, in_ready=0 next cycle.
- AES_DECRYPT_EN: decrypt=1 with the 128/192/256 ciphertexts above -> 00112233445566778899aabbccddeeff. Interleave encrypt/decrypt blocks under one key -> all correct.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM encodings and GF(2^8) round helpers
package aes_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] KEYEXP = 2'd1;
  localparam logic [1:0] ROUND  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction
  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
            gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
  endfunction
  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = s;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return o;
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = s;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
    return o;
  endfunction
  // byte 4c+r of the block is row r, column c
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box (INV=1 gives the inverse), built from GF(2^8) inversion and the affine map
module aes_sbox
  import aes_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, q;
    p = x;
    q = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gmul(p, p);
      q = gmul(q, p);
    end
    return q;
  endfunction
  logic [7:0] v;
  assign v = gf_inv(INV ? rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05 : a);
  assign y = INV ? v : v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 core, one round per clock; inverse cipher enabled by AES_DECRYPT_EN
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        data_in,
`ifdef AES_DECRYPT_EN
  input  logic                decrypt,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        data_out,
  output logic                busy
);
  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = 4 * (NR + 1);
  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
  end
  logic [1:0]   state;
  logic         key_loaded, last;
  logic [5:0]   i, rb;
  logic [2:0]   kmod;
  logic [3:0]   rci, r;
  logic [31:0]  w [NW];
  logic [31:0]  wp, sw, t, wn;
  logic [127:0] st, sb, rk_r, enc_nxt, round_nxt;
  assign key_ready = state == IDLE;
  assign in_ready  = key_ready && key_loaded && !key_valid;
  assign busy      = !key_ready;
  assign rb        = {r, 2'b00};
  assign rk_r      = {w[rb], w[rb + 6'd1], w[rb + 6'd2], w[rb + 6'd3]};
  for (genvar g = 0; g < 16; g++) begin : g_sb
    aes_sbox #(.INV(1'b0)) u_sb (.a(st[8*g +: 8]), .y(sb[8*g +: 8]));
  end
  assign wp = w[i - 6'd1];
  for (genvar g = 0; g < 4; g++) begin : g_sw
    aes_sbox #(.INV(1'b0)) u_sw (.a(wp[8*g +: 8]), .y(sw[8*g +: 8]));
  end
  assign t  = kmod == 3'd0 ? {sw[23:0], sw[31:24]} ^ {RCON[rci], 24'h0} :
              (NK == 8 && kmod == 3'd4) ? sw : wp;
  assign wn = w[i - 6'(NK)] ^ t;
  assign enc_nxt = (r == 4'(NR) ? shift_rows(sb) : mix_columns(shift_rows(sb))) ^ rk_r;
`ifdef AES_DECRYPT_EN
  logic         dec;
  logic [127:0] isb, ark;
  for (genvar g = 0; g < 16; g++) begin : g_isb
    aes_sbox #(.INV(1'b1)) u_isb (.a(st[8*g +: 8]), .y(isb[8*g +: 8]));
  end
  assign ark       = inv_shift_rows(isb) ^ rk_r;
  assign last      = dec ? r == 4'd0 : r == 4'(NR);
  assign round_nxt = dec ? (r == 4'd0 ? ark : inv_mix_columns(ark)) : enc_nxt;
`else
  assign last      = r == 4'(NR);
  assign round_nxt = enc_nxt;
`endif
  // round-key store: key words on the key handshake, then one expanded word per KEYEXP cycle
  always_ff @(posedge clk)
    if (state == IDLE && key_valid)
      for (int k = 0; k < NK; k++) w[k] <= key_in[KEY_BITS-1-32*k -: 32];
    else if (state == KEYEXP)
      w[i] <= wn;
  // control FSM: key expansion sequencing, block rounds and output hold
  always_ff @(posedge clk)
    if (!rst_n) begin
      state      <= IDLE;
      key_loaded <= 1'b0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      st         <= '0;
      i          <= '0;
      kmod       <= '0;
      rci        <= '0;
      r          <= '0;
`ifdef AES_DECRYPT_EN
      dec        <= 1'b0;
`endif
    end else
      case (state)
        IDLE:
          if (key_valid) begin
            key_loaded <= 1'b0;
            i          <= 6'(NK);
            kmod       <= '0;
            rci        <= '0;
            state      <= KEYEXP;
          end else if (in_valid && key_loaded) begin
`ifdef AES_DECRYPT_EN
            dec   <= decrypt;
            st    <= data_in ^ (decrypt ? {w[4*NR], w[4*NR+1], w[4*NR+2], w[4*NR+3]} : {w[0], w[1], w[2], w[3]});
            r     <= decrypt ? 4'(NR - 1) : 4'd1;
`else
            st    <= data_in ^ {w[0], w[1], w[2], w[3]};
            r     <= 4'd1;
`endif
            state <= ROUND;
          end
        KEYEXP: begin
          i    <= i + 6'd1;
          kmod <= kmod == 3'(NK - 1) ? 3'd0 : kmod + 3'd1;
          rci  <= kmod == 3'd0 ? rci + 4'd1 : rci;
          if (i == 6'(NW - 1)) begin
            key_loaded <= 1'b1;
            state      <= IDLE;
          end
        end
        ROUND:
          if (last) begin
            data_out  <= round_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            st <= round_nxt;
`ifdef AES_DECRYPT_EN
            r  <= dec ? r - 4'd1 : r + 4'd1;
`else
            r  <= r + 4'd1;
`endif
          end
        default:
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: directed FIPS-197 vectors against 128/192/256-bit instances
module tb_aes_iter_core;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b1;
  logic [127:0] data_in = '0;
`ifdef AES_DECRYPT_EN
  logic decrypt = 1'b0;
`endif
  logic [127:0] key128 = 128'h000102030405060708090a0b0c0d0e0f;
  logic [191:0] key192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  logic [255:0] key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  logic kv [3], iv [3], kr [3], ir [3], ov [3], bz [3];
  logic [127:0] dout [3];
  logic [127:0] ct_tab [3];
  int exp_cyc [3], exp_lat [3];
  int nchk = 0, nerr = 0, cyc_now = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;
  aes_iter_core #(.KEY_BITS(128)) u_aes128 (.clk(clk), .rst_n(rst_n), .key_valid(kv[0]), .key_ready(kr[0]), .key_in(key128),
    .in_valid(iv[0]), .in_ready(ir[0]), .data_in(data_in),
`ifdef AES_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .data_out(dout[0]), .busy(bz[0]));
  aes_iter_core #(.KEY_BITS(192)) u_aes192 (.clk(clk), .rst_n(rst_n), .key_valid(kv[1]), .key_ready(kr[1]), .key_in(key192),
    .in_valid(iv[1]), .in_ready(ir[1]), .data_in(data_in),
`ifdef AES_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .data_out(dout[1]), .busy(bz[1]));
  aes_iter_core #(.KEY_BITS(256)) u_aes256 (.clk(clk), .rst_n(rst_n), .key_valid(kv[2]), .key_ready(kr[2]), .key_in(key256),
    .in_valid(iv[2]), .in_ready(ir[2]), .data_in(data_in),
`ifdef AES_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .data_out(dout[2]), .busy(bz[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int u, output int cyc);
    kv[u] = 1'b1;
    tick();
    kv[u] = 1'b0;
    cyc = 0;
    while (kr[u] !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_blk(input int u, input logic dec, input logic [127:0] blk, output logic [127:0] res, output int lat);
    int n;
    n = 0;
`ifdef AES_DECRYPT_EN
    decrypt = dec;
`endif
    data_in = blk;
    iv[u] = 1'b1;
    while (ir[u] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    iv[u] = 1'b0;
    lat = 0;
    if (n >= 50) lat = -1;
    else while (ov[u] !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    res = dout[u];
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    nchk++; if (kr[0] !== 1'b1) begin nerr++; $display("FAIL reset_key_ready: got %b expected 1", kr[0]); end
    nchk++; if (ir[0] !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %b expected 0", ir[0]); end
    nchk++; if (ov[0] !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b expected 0", ov[0]); end
    nchk++; if (dout[0] !== 128'h0) begin nerr++; $display("FAIL reset_data_out: got %h expected 0", dout[0]); end
    nchk++; if (bz[0] !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", bz[0]); end
    nchk++; if (kr[1] !== 1'b1 || kr[2] !== 1'b1) begin nerr++; $display("FAIL reset_key_ready_192_256: got %b%b expected 11", kr[1], kr[2]); end
  endtask

  task automatic test_no_key();
    int cyc;
    logic bad;
    out_ready = 1'b0;
    data_in = PT;
    iv[0] = 1'b1;
    repeat (3) begin
      tick();
      nchk++; if (ir[0] !== 1'b0 || bz[0] !== 1'b0) begin nerr++; $display("FAIL nokey_ignored: in_ready %b busy %b expected 0 0", ir[0], bz[0]); end
    end
    kv[0] = 1'b1;
    #1;
    nchk++; if (ir[0] !== 1'b0) begin nerr++; $display("FAIL key_wins: in_ready got %b expected 0", ir[0]); end
    tick();
    kv[0] = 1'b0;
    cyc = 0;
    bad = 1'b0;
    while (kr[0] !== 1'b1 && cyc < 200) begin
      if (ir[0] !== 1'b0 || bz[0] !== 1'b1) bad = 1'b1;
      tick();
      cyc++;
    end
    nchk++; if (bad !== 1'b0) begin nerr++; $display("FAIL keyexp_blocks: in_ready/busy wrong during expansion, got %b expected 0", bad); end
    nchk++; if (cyc !== 40) begin nerr++; $display("FAIL keyexp_128_cycles: got %0d expected 40", cyc); end
    nchk++; if (ir[0] !== 1'b1) begin nerr++; $display("FAIL in_ready_after_key: got %b expected 1", ir[0]); end
  endtask

  task automatic test_backpressure();
    int lat;
    tick();
    iv[0] = 1'b0;
    lat = 0;
    while (ov[0] !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    nchk++; if (lat !== 10) begin nerr++; $display("FAIL latency_128: got %0d expected 10", lat); end
    nchk++; if (dout[0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin nerr++; $display("FAIL enc_128: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", dout[0]); end
    repeat (20) begin
      tick();
      nchk++; if (dout[0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin nerr++; $display("FAIL hold_data: got %h", dout[0]); end
      nchk++; if (ov[0] !== 1'b1) begin nerr++; $display("FAIL hold_valid: got %b expected 1", ov[0]); end
      nchk++; if (ir[0] !== 1'b0 || kr[0] !== 1'b0) begin nerr++; $display("FAIL hold_ready: in %b key %b expected 0 0", ir[0], kr[0]); end
    end
    out_ready = 1'b1;
    tick();
    nchk++; if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || kr[0] !== 1'b1) begin nerr++; $display("FAIL release: valid %b busy %b key_ready %b expected 0 0 1", ov[0], bz[0], kr[0]); end
  endtask

  task automatic test_back_to_back();
    int t [2];
    int got, guard;
    got = 0;
    guard = 0;
    t[0] = 0;
    t[1] = 0;
    out_ready = 1'b1;
    data_in = PT;
    iv[0] = 1'b1;
    while (got < 2 && guard < 100) begin
      tick();
      guard++;
      if (ov[0] === 1'b1) begin
        t[got] = cyc_now;
        nchk++; if (dout[0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin nerr++; $display("FAIL b2b_data %0d: got %h", got, dout[0]); end
        got++;
      end
    end
    iv[0] = 1'b0;
    nchk++; if (got !== 2) begin nerr++; $display("FAIL b2b_count: got %0d expected 2", got); end
    nchk++; if (t[1] - t[0] !== 12) begin nerr++; $display("FAIL b2b_period: got %0d expected 12", t[1] - t[0]); end
    tick();
    tick();
    nchk++; if (bz[0] !== 1'b0) begin nerr++; $display("FAIL b2b_idle: busy got %b expected 0", bz[0]); end
  endtask

`ifdef AES_DECRYPT_EN
  task automatic test_interleave();
    logic [127:0] res;
    int lat;
    for (int k = 0; k < 4; k++) begin
      run_blk(0, k[0], k[0] ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a : PT, res, lat);
      nchk++; if (res !== (k[0] ? PT : 128'h69c4e0d86a7b0430d8cdb78070b4c55a)) begin nerr++; $display("FAIL interleave %0d: got %h", k, res); end
      nchk++; if (lat !== 10) begin nerr++; $display("FAIL interleave_lat %0d: got %0d expected 10", k, lat); end
    end
  endtask
`endif

  task automatic test_new_key();
    logic [127:0] res;
    int cyc, lat;
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    load_key(0, cyc);
    nchk++; if (cyc !== 40) begin nerr++; $display("FAIL rekey_cycles: got %0d expected 40", cyc); end
    run_blk(0, 1'b0, PTB, res, lat);
    nchk++; if (res !== CTB) begin nerr++; $display("FAIL rekey_enc: got %h expected %h", res, CTB); end
    nchk++; if (lat !== 10) begin nerr++; $display("FAIL rekey_lat: got %0d expected 10", lat); end
`ifdef AES_DECRYPT_EN
    run_blk(0, 1'b1, CTB, res, lat);
    nchk++; if (res !== PTB) begin nerr++; $display("FAIL rekey_dec: got %h expected %h", res, PTB); end
`endif
  endtask

  task automatic test_reset_mid_round();
    data_in = PT;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    nchk++; if (bz[0] !== 1'b1) begin nerr++; $display("FAIL midround_busy: got %b expected 1", bz[0]); end
    rst_n = 1'b0;
    tick();
    nchk++; if (ov[0] !== 1'b0 || ir[0] !== 1'b0 || bz[0] !== 1'b0) begin nerr++; $display("FAIL midround_reset: valid %b in_ready %b busy %b expected 0 0 0", ov[0], ir[0], bz[0]); end
    rst_n = 1'b1;
    iv[0] = 1'b1;
    tick();
    nchk++; if (ir[0] !== 1'b0) begin nerr++; $display("FAIL key_lost_after_reset: in_ready got %b expected 0", ir[0]); end
    iv[0] = 1'b0;
  endtask

  task automatic test_key_sizes();
    logic [127:0] res;
    int cyc, lat;
    for (int u = 1; u < 3; u++) begin
      load_key(u, cyc);
      nchk++; if (cyc !== exp_cyc[u]) begin nerr++; $display("FAIL keyexp_cycles u%0d: got %0d expected %0d", u, cyc, exp_cyc[u]); end
      run_blk(u, 1'b0, PT, res, lat);
      nchk++; if (res !== ct_tab[u]) begin nerr++; $display("FAIL enc u%0d: got %h expected %h", u, res, ct_tab[u]); end
      nchk++; if (lat !== exp_lat[u]) begin nerr++; $display("FAIL latency u%0d: got %0d expected %0d", u, lat, exp_lat[u]); end
`ifdef AES_DECRYPT_EN
      run_blk(u, 1'b1, ct_tab[u], res, lat);
      nchk++; if (res !== PT) begin nerr++; $display("FAIL dec u%0d: got %h expected %h", u, res, PT); end
      nchk++; if (lat !== exp_lat[u]) begin nerr++; $display("FAIL dec_latency u%0d: got %0d expected %0d", u, lat, exp_lat[u]); end
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      kv[u] = 1'b0;
      iv[u] = 1'b0;
    end
    ct_tab[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    ct_tab[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    ct_tab[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    exp_cyc = '{40, 46, 52};
    exp_lat = '{10, 12, 14};
    test_reset();
    test_no_key();
    test_backpressure();
    test_back_to_back();
`ifdef AES_DECRYPT_EN
    test_interleave();
`endif
    test_new_key();
    test_reset_mid_round();
    test_key_sizes();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
